data_mem_responder: RTL

//  Multi-cycle data-memory responder for the MEM stage. Sits at the far end of the MEM-stage

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one word request at a time,
// stalls the pipeline for the access, then returns a one-cycle response with data or error.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              req_ready_o,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              stall_o
);

    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IdxW  = ADDR_W - 2;
    localparam int unsigned MemAw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [IdxW-1:0]   acc_idx;
    logic [MemAw-1:0]  mem_idx;
    logic              acc_err;
    logic              enter_resp;
    logic              mem_we;

    // With LATENCY==1 the array is accessed on the acceptance edge, before the request is latched.
    assign acc_we    = (state_q == StIdle) ? req_we_i    : we_q;
    assign acc_addr  = (state_q == StIdle) ? req_addr_i  : addr_q;
    assign acc_wdata = (state_q == StIdle) ? req_wdata_i : wdata_q;
    assign acc_idx   = acc_addr[ADDR_W-1:2];
    assign mem_idx   = acc_idx[MemAw-1:0];
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_idx >= IdxW'(DEPTH_WORDS));
    assign mem_we    = enter_resp && acc_we && !acc_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        enter_resp   = 1'b0;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        stall_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                stall_o     = req_valid_i;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d   = CntW'(LATENCY - 2);
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                resp_valid_o = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'h0 : mem_q[mem_idx];
        end
    end

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; reset only blocks a commit that lands on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem_q[mem_idx] <= acc_wdata;
        end
    end

endmodule
